// File: rtl/projection_mem_bank.sv
// projection_mem_bank: loadable projection-word store for the HD encoder.
// Words arrive LANES per beat over a valid/ready stream. Once the array is
// full, LANES independent registered reads can be made every cycle.
module projection_mem_bank #(
  parameter int DHV_SIZE = 4000,
  parameter int WORD_W   = 16,
  parameter int LANES    = 2,
  parameter int DEPTH    = DHV_SIZE / WORD_W,
  parameter int ADDR_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*WORD_W-1:0]   in_data,
  output logic                      load_done,
  output logic [ADDR_W:0]           word_count,
  input  logic                      rd_en,
  input  logic [LANES*ADDR_W-1:0]   rd_addr,
  output logic [LANES*WORD_W-1:0]   rd_data,
  output logic                      rd_valid,
  output logic [LANES-1:0]          rd_err
);

  // The write pointer can run up to LANES-1 past DEPTH on the final beat,
  // so it gets two bits of headroom over the read address.
  localparam int PW = ADDR_W + 2;
  localparam logic [PW-1:0]   DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0]   LANES_P = PW'(LANES);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       wp;
  logic                accept;
  logic                last_beat;
  logic                rd_svc;
  logic [ADDR_W:0]     n_written;
  logic [PW-1:0]       waddr [LANES];
  logic [LANES-1:0]    wen;
  logic [ADDR_W-1:0]   raddr [LANES];
  logic [LANES-1:0]    rin_range;

  logic [WORD_W-1:0]   mem [DEPTH];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, handshake and per-lane address decode.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == LOAD);
    load_done = (state == READY);
    accept    = (state == LOAD) && in_valid && !load_start;
    last_beat = accept && ((wp + LANES_P) >= DEPTH_P);
    rd_svc    = (state == READY) && rd_en && !load_start;
    if ((DEPTH_P - wp) < LANES_P) n_written = (ADDR_W + 1)'(DEPTH_P - wp);
    else                          n_written = (ADDR_W + 1)'(LANES);
    for (int unsigned i = 0; i < LANES; i++) begin
      waddr[i]     = wp + PW'(i);
      wen[i]       = accept && (waddr[i] < DEPTH_P);
      raddr[i]     = rd_addr[i*ADDR_W +: ADDR_W];
      rin_range[i] = ({1'b0, raddr[i]} < DEPTH_A);
    end
    case (state)
      IDLE:    if (load_start) state_nxt = LOAD;
      LOAD:    if (load_start) state_nxt = LOAD;
               else if (last_beat) state_nxt = READY;
      READY:   if (load_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Write pointer and written-word counter; load_start restarts both.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp         <= '0;
      word_count <= '0;
    end else if (load_start) begin
      wp         <= '0;
      word_count <= '0;
    end else if (accept) begin
      wp         <= wp + LANES_P;
      word_count <= word_count + n_written;
    end
  end

  // Array write; lanes past the end of the array are dropped.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!reset && wen[i]) mem[waddr[i][ADDR_W-1:0]] <= in_data[i*WORD_W +: WORD_W];
    end
  end

  // Registered read ports; data and error hold when no read is serviced.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= '0;
    end else begin
      rd_valid <= rd_svc;
      if (rd_svc) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (rin_range[i]) begin
            rd_data[i*WORD_W +: WORD_W] <= mem[raddr[i]];
            rd_err[i]                   <= 1'b0;
          end else begin
            rd_data[i*WORD_W +: WORD_W] <= '0;
            rd_err[i]                   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_projection_mem_bank.sv
// Directed self-checking bench for projection_mem_bank: a default 2-lane
// instance checked through a read scoreboard, plus a 3-lane instance for
// the partial final beat.
module tb_projection_mem_bank;
  localparam int W  = 16;
  localparam int L  = 2;
  localparam int AW = 8;
  localparam int D  = 250;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, load_start, in_valid, in_ready, load_done;
  logic              rd_en, rd_valid;
  logic [L*W-1:0]    in_data, rd_data;
  logic [AW:0]       word_count;
  logic [L*AW-1:0]   rd_addr;
  logic [L-1:0]      rd_err;

  logic              load_start3, in_valid3, in_ready3, load_done3, rd_en3, rd_valid3;
  logic [3*W-1:0]    in_data3, rd_data3;
  logic [AW:0]       word_count3;
  logic [3*AW-1:0]   rd_addr3;
  logic [2:0]        rd_err3;

  projection_mem_bank dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .load_done(load_done),
    .word_count(word_count), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err)
  );

  projection_mem_bank #(.DHV_SIZE(4000), .WORD_W(16), .LANES(3), .DEPTH(250), .ADDR_W(8)) dut3 (
    .clk(clk), .reset(reset), .load_start(load_start3), .in_valid(in_valid3),
    .in_ready(in_ready3), .in_data(in_data3), .load_done(load_done3),
    .word_count(word_count3), .rd_en(rd_en3), .rd_addr(rd_addr3),
    .rd_data(rd_data3), .rd_valid(rd_valid3), .rd_err(rd_err3)
  );

  int tests = 0;
  int fails = 0;

  logic [W-1:0] model [D];

  typedef struct {
    logic           v;
    logic [L*W-1:0] d;
    logic [L-1:0]   e;
    string          tag;
  } exp_t;
  exp_t sb[$];
  logic [L*W-1:0] last_d = '0;
  logic [L-1:0]   last_e = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mdl(input int a);
    if (a >= D) return '0;
    return model[a];
  endfunction

  // One clock; then compare any pending scoreboard entry.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_valid"}, 64'(rd_valid), 64'(e.v));
      chk({e.tag, "_data"},  64'(rd_data),  64'(e.d));
      chk({e.tag, "_err"},   64'(rd_err),   64'(e.e));
    end
  endtask

  task automatic rd(input string tag, input int a0, input int a1, input logic svc);
    exp_t e;
    rd_en   = 1'b1;
    rd_addr = {AW'(a1), AW'(a0)};
    e.tag   = tag;
    if (svc) begin
      e.v = 1'b1;
      e.d = {mdl(a1), mdl(a0)};
      e.e = {(a1 >= D), (a0 >= D)};
      last_d = e.d;
      last_e = e.e;
    end else begin
      e.v = 1'b0;
      e.d = last_d;
      e.e = last_e;
    end
    sb.push_back(e);
  endtask

  task automatic push_idle(input string tag);
    exp_t e;
    e.tag = tag; e.v = 1'b0; e.d = last_d; e.e = last_e;
    sb.push_back(e);
  endtask

  task automatic beat(input int k, input logic [W-1:0] lo, input logic [W-1:0] hi);
    in_valid = 1'b1;
    in_data  = {hi, lo};
    cyc();
    model[2*k]     = lo;
    model[2*k + 1] = hi;
  endtask

  initial begin
    logic [W-1:0] v16;
    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    load_start3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; rd_en3 = 1'b0; rd_addr3 = '0;
    cyc(); cyc();
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_load_done", 64'(load_done), 0);
    chk("rst_word_count", 64'(word_count), 0);
    chk("rst_rd_valid", 64'(rd_valid), 0);
    chk("rst_rd_data", 64'(rd_data), 0);
    chk("rst_rd_err", 64'(rd_err), 0);
    reset = 1'b0;

    rd("idle_rd", 0, 1, 1'b0);
    cyc();
    rd_en = 1'b0;

    // Full load, k = 0..124, with a read attempt during the first beat.
    load_start = 1'b1; cyc(); load_start = 1'b0;
    chk("load_in_ready", 64'(in_ready), 1);
    chk("load_wc0", 64'(word_count), 0);
    rd("load_rd", 0, 1, 1'b0);
    for (int k = 0; k < 125; k++) begin
      beat(k, W'(2*k), W'(2*k + 1));
      rd_en = 1'b0;
      if (k == 0)   chk("load_wc_first", 64'(word_count), 2);
      if (k == 123) chk("load_done_early", 64'(load_done), 0);
    end
    in_valid = 1'b0;
    chk("full_load_done", 64'(load_done), 1);
    chk("full_in_ready", 64'(in_ready), 0);
    chk("full_wc", 64'(word_count), 250);

    for (int k = 0; k < 125; k++) begin
      rd("rd_seq", 2*k, 2*k + 1, 1'b1);
      cyc();
    end
    rd_en = 1'b0;
    push_idle("rd_drop");
    cyc();

    rd("oor_hi", 249, 250, 1'b1); cyc();
    rd("oor_lo", 255, 0, 1'b1);   cyc();
    rd_en = 1'b0;

    // Read colliding with load_start: the load wins.
    rd("rd_vs_load", 0, 1, 1'b0);
    load_start = 1'b1; cyc(); load_start = 1'b0; rd_en = 1'b0;
    chk("coll_load_done", 64'(load_done), 0);
    chk("coll_in_ready", 64'(in_ready), 1);

    for (int k = 0; k < 50; k++) beat(k, 16'hFFFF, 16'h0F0F);
    chk("part_wc", 64'(word_count), 100);

    // Restart with in_valid high: that beat must not be taken.
    load_start = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678;
    cyc();
    load_start = 1'b0;
    chk("restart_wc", 64'(word_count), 0);
    chk("restart_in_ready", 64'(in_ready), 1);
    for (int k = 0; k < 125; k++) begin
      beat(k, 16'hA000 ^ W'(2*k), 16'hA000 ^ W'(2*k + 1));
      if (k == 0) chk("restart_wc_first", 64'(word_count), 2);
    end
    in_valid = 1'b0;
    chk("restart_wc_full", 64'(word_count), 250);
    chk("restart_load_done", 64'(load_done), 1);
    for (int k = 0; k < 125; k++) begin
      rd("rd_new", k, 249 - k, 1'b1);
      cyc();
    end
    rd_en = 1'b0;

    // Reset during a load, in_valid held high throughout.
    load_start = 1'b1; cyc(); load_start = 1'b0;
    for (int k = 0; k < 10; k++) beat(k, 16'h1111, 16'h2222);
    reset = 1'b1;
    cyc();
    chk("mrst_in_ready", 64'(in_ready), 0);
    chk("mrst_load_done", 64'(load_done), 0);
    chk("mrst_wc", 64'(word_count), 0);
    reset = 1'b0;
    repeat (3) cyc();
    chk("mrst_hold_in_ready", 64'(in_ready), 0);
    chk("mrst_hold_wc", 64'(word_count), 0);
    chk("mrst_hold_done", 64'(load_done), 0);
    in_valid = 1'b0;

    // Three lanes: 84 beats, lanes 1 and 2 of the last beat fall off the end.
    load_start3 = 1'b1; cyc(); load_start3 = 1'b0;
    for (int k = 0; k < 84; k++) begin
      in_valid3 = 1'b1;
      if (k == 83) in_data3 = {16'hBEEF, 16'hDEAD, 16'h5000 + 16'd249};
      else begin
        for (int j = 0; j < 3; j++) begin
          v16 = 16'h5000 + W'(3*k + j);
          in_data3[j*W +: W] = v16;
        end
      end
      cyc();
      if (k == 82) chk("l3_wc_82", 64'(word_count3), 249);
    end
    in_valid3 = 1'b0;
    chk("l3_wc", 64'(word_count3), 250);
    chk("l3_done", 64'(load_done3), 1);
    rd_en3 = 1'b1; rd_addr3 = {8'd248, 8'd249, 8'd0};
    cyc();
    chk("l3_rd_data", 64'(rd_data3), 64'({16'h5000 + 16'd248, 16'h5000 + 16'd249, 16'h5000}));
    chk("l3_rd_err", 64'(rd_err3), 0);
    chk("l3_rd_valid", 64'(rd_valid3), 1);
    rd_addr3 = {8'd252, 8'd251, 8'd250};
    cyc();
    rd_en3 = 1'b0;
    chk("l3_oor_data", 64'(rd_data3), 0);
    chk("l3_oor_err", 64'(rd_err3), 64'(3'b111));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/projection_mem_bank.md
# projection_mem_bank

Parametrised projection-vector store for the HD encoder. It loads a hypervector's projection words through a valid/ready stream, LANES words per beat, into an internal DEPTH-word array. It then serves LANES independent random reads per cycle, with registered data, a valid flag and an out-of-range flag. It sits between the projection-matrix loader and the encoder datapath, and replaces the fixed 2-port, write-once store.

## Interface
- DHV_SIZE, 4000: hypervector dimension in bits.
- WORD_W, 16: bits per stored word.
- LANES, 2: words written per load beat and read ports per cycle; range 1..8.
- DEPTH, DHV_SIZE/WORD_W (250): number of stored words.
- ADDR_W, 8: address width; must satisfy 2**ADDR_W >= DEPTH.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- load_start  in  1  single-cycle pulse; begins or restarts a load.
- in_valid  in  1  load beat valid.
- in_ready  out  1  load beat accepted when in_valid && in_ready.
- in_data  in  LANES*WORD_W  lane i occupies bits [i*WORD_W +: WORD_W].
- load_done  out  1  array fully loaded; reads permitted.
- word_count  out  ADDR_W+1  number of words written since the last load_start.
- rd_en  in  1  read request; all lanes are read together.
- rd_addr  in  LANES*ADDR_W  per-lane read address.
- rd_data  out  LANES*WORD_W  per-lane read data.
- rd_valid  out  1  rd_data is valid.
- rd_err  out  LANES  per-lane flag: the address was >= DEPTH.

## Operation
- States: IDLE, LOAD, READY. Reset puts the block in IDLE.
- IDLE -> LOAD on load_start. READY -> LOAD on load_start. LOAD -> LOAD on load_start, which restarts the load.
- Entering LOAD:
  - The write pointer wp and word_count are cleared to 0.
  - load_done is cleared to 0.
  - Array contents are not cleared.
- In LOAD, in_ready = 1. In every other state, in_ready = 0.
- On an accepted beat:
  - For each lane i, if wp+i < DEPTH, write in_data lane i to mem[wp+i].
  - Lanes with wp+i >= DEPTH are dropped without a write.
  - wp increases by LANES. word_count increases by the number of lanes actually written.
- The accepted beat with wp+LANES >= DEPTH is the final beat. The block moves to READY, and load_done = 1 from the next cycle.
- Reads are serviced only in READY, and only when load_start is not asserted in the same cycle.
- For each serviced read, each lane i is handled independently:
  - If rd_addr[i] < DEPTH: rd_data[i] = mem[rd_addr[i]], rd_err[i] = 0.
  - Otherwise: rd_data[i] = 0, rd_err[i] = 1.
- rd_en in IDLE or LOAD is ignored: rd_valid stays 0 and rd_data/rd_err hold their previous values.
- Simultaneous load_start and rd_en in READY: the load wins and the read is dropped.
- load_start while in_valid is high in the same cycle: the beat is not accepted, because in_ready was 0 or the load is restarting. The first beat can be accepted the following cycle.

## Timing
- Reset values:
  - Outputs: in_ready = 0, load_done = 0, word_count = 0, rd_valid = 0, rd_data = 0, rd_err = 0.
  - Internal: state = IDLE, wp = 0.
  - Array contents are undefined after reset.
- A reset asserted mid-load aborts the load: IDLE the next cycle, load_done = 0.
- load_start at cycle t: in_ready = 1 from t+1.
- Load throughput is one beat per cycle. A full load takes ceil(DEPTH/LANES) accepted beats.
- Final beat accepted at cycle t: in_ready = 0 and load_done = 1 at t+1. A read issued at t+1 returns data at t+2.
- Read latency is 1 cycle:
  - rd_en sampled at t gives rd_data, rd_err and rd_valid = 1 at t+1.
  - rd_valid is 0 in any cycle that follows a cycle with no serviced read.
- Back-to-back reads are supported every cycle.
- Write-to-read hazard: none. Reads are only enabled after the final write has completed.

## Test plan
- Default parameters, full load: reset, load_start, then 125 beats with lane0 = 2k and lane1 = 2k+1 for k = 0..124.
  - Required: load_done rises the cycle after beat 124; word_count = 250.
  - Reads of addresses (0,1) through (248,249) return equal data with rd_valid one cycle after each rd_en.
- Partial last beat with LANES=3, DEPTH=250: 84 beats.
  - Required: beat 83 writes only mem[249]; its lanes 1 and 2 are dropped; word_count = 250; no write wraps to address 0.
- Out-of-range read: rd_addr = (249, 250) with defaults.
  - Required: rd_data = (mem[249], 0), rd_err = 2'b10, rd_valid = 1.
- Reads outside READY: rd_en during IDLE and during LOAD.
  - Required: rd_valid stays 0.
  - Also: in READY, rd_en together with load_start gives rd_valid = 0, load_done = 0 and in_ready = 1 on the next cycle.
- Restart mid-load: load_start after 50 beats, then a full 125-beat load of new data.
  - Required: word_count restarts at 0, reaches 250, and all reads return the new data.
- Reset mid-load after 10 beats, with in_valid held high afterwards.
  - Required: in_ready = 0 and load_done = 0 from the next cycle, and no further beats are accepted until load_start.
